// File: rtl/gpio_wb_arbiter.sv
// gpio_wb_arbiter: two-master round-robin Wishbone arbiter for a GPIO slave; optional stall timeout via `GPIO_ARB_TIMEOUT_EN
module gpio_wb_arbiter #(
    parameter int wb_adr_width   = 3,
    parameter int wb_dat_width   = 8,
    parameter int timeout_cycles = 255
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst_n,
    input  logic [wb_adr_width-1:0] m0_adr_i,
    input  logic [wb_dat_width-1:0] m0_dat_i,
    input  logic                    m0_we_i,
    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    output logic [wb_dat_width-1:0] m0_dat_o,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    output logic                    m0_rty_o,
    input  logic [wb_adr_width-1:0] m1_adr_i,
    input  logic [wb_dat_width-1:0] m1_dat_i,
    input  logic                    m1_we_i,
    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    output logic [wb_dat_width-1:0] m1_dat_o,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic                    m1_rty_o,
    output logic [wb_adr_width-1:0] s_adr_o,
    output logic [wb_dat_width-1:0] s_dat_o,
    output logic                    s_we_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    input  logic [wb_dat_width-1:0] s_dat_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic                    s_rty_i,
    output logic [1:0]              grant_o
);
    localparam logic [1:0] idle = 2'd0, own0 = 2'd1, own1 = 2'd2;
    logic [1:0] state_q, state_d;
    logic       last_q;
    logic       o0, o1, tmo;
    // gating with reset makes ownership vanish in the reset cycle itself
    assign o0 = wb_rst_n && state_q == own0;
    assign o1 = wb_rst_n && state_q == own1;
`ifdef GPIO_ARB_TIMEOUT_EN
    logic [7:0] cnt_q;
    assign tmo = (o0 || o1) && cnt_q == 8'(timeout_cycles);
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n || !(o0 || o1) || tmo || s_ack_i || s_err_i)
            cnt_q <= '0;
        else if (s_stb_o)
            cnt_q <= cnt_q + 8'd1;
    end
`else
    assign tmo = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        if (state_q == idle)
            state_d = (m0_cyc_i && m1_cyc_i) ? (last_q ? own0 : own1) :
                      m0_cyc_i ? own0 : m1_cyc_i ? own1 : idle;
        else if (state_q == own0)
            state_d = m0_cyc_i ? own0 : idle;
        else if (state_q == own1)
            state_d = m1_cyc_i ? own1 : idle;
        else
            state_d = idle;
    end
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q <= idle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == own0 && !m0_cyc_i)
                last_q <= 1'b0;
            else if (state_q == own1 && !m1_cyc_i)
                last_q <= 1'b1;
        end
    end
    assign s_adr_o  = o0 ? m0_adr_i : o1 ? m1_adr_i : '0;
    assign s_dat_o  = o0 ? m0_dat_i : o1 ? m1_dat_i : '0;
    assign s_we_o   = o0 ? m0_we_i  : o1 ? m1_we_i  : 1'b0;
    assign s_cyc_o  = o0 ? m0_cyc_i : o1 ? m1_cyc_i : 1'b0;
    assign s_stb_o  = (o0 ? m0_stb_i : o1 ? m1_stb_i : 1'b0) && !tmo;
    assign m0_dat_o = o0 ? s_dat_i : '0;
    assign m0_ack_o = o0 && s_ack_i;
    assign m0_err_o = o0 && (s_err_i || tmo);
    assign m0_rty_o = o0 && s_rty_i;
    assign m1_dat_o = o1 ? s_dat_i : '0;
    assign m1_ack_o = o1 && s_ack_i;
    assign m1_err_o = o1 && (s_err_i || tmo);
    assign m1_rty_o = o1 && s_rty_i;
    assign grant_o  = {o1, o0};
endmodule

// File: tb/tb_gpio_wb_arbiter.sv
// tb_gpio_wb_arbiter: directed and random checks of gpio_wb_arbiter against an owner/round-robin model
module tb_gpio_wb_arbiter;
    localparam int TO = 4;
    logic       wb_clk = 1'b0, wb_rst_n = 1'b0;
    logic [2:0] m0_adr_i = '0, m1_adr_i = '0, s_adr_o;
    logic [7:0] m0_dat_i = '0, m1_dat_i = '0, s_dat_o, s_dat_i = '0, m0_dat_o, m1_dat_o;
    logic       m0_we_i = 0, m0_cyc_i = 0, m0_stb_i = 0, m1_we_i = 0, m1_cyc_i = 0, m1_stb_i = 0;
    logic       m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic       s_we_o, s_cyc_o, s_stb_o, s_ack_i = 0, s_err_i = 0, s_rty_i = 0;
    logic [1:0] grant_o;
    int checks = 0, errors = 0;
    int own = 0;
    bit last = 1;
    int cnt = 0;

    always #5 wb_clk = ~wb_clk;

    gpio_wb_arbiter #(.wb_adr_width(3), .wb_dat_width(8), .timeout_cycles(TO)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .grant_o(grant_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic bit timed_out();
`ifdef GPIO_ARB_TIMEOUT_EN
        return wb_rst_n && own != 0 && cnt == TO;
`else
        return 1'b0;
`endif
    endfunction

    task automatic settle();
        int o;
        bit t;
        #1;
        o = wb_rst_n ? own : 0;
        t = timed_out();
        chk("grant", 32'(grant_o), o == 1 ? 32'd1 : o == 2 ? 32'd2 : 32'd0);
        chk("slave", 32'({s_adr_o, s_dat_o, s_we_o, s_cyc_o, s_stb_o}),
            o == 1 ? 32'({m0_adr_i, m0_dat_i, m0_we_i, m0_cyc_i, m0_stb_i && !t}) :
            o == 2 ? 32'({m1_adr_i, m1_dat_i, m1_we_i, m1_cyc_i, m1_stb_i && !t}) : 32'd0);
        chk("m0", 32'({m0_dat_o, m0_ack_o, m0_err_o, m0_rty_o}),
            o == 1 ? 32'({s_dat_i, s_ack_i, s_err_i || t, s_rty_i}) : 32'd0);
        chk("m1", 32'({m1_dat_o, m1_ack_o, m1_err_o, m1_rty_o}),
            o == 2 ? 32'({s_dat_i, s_ack_i, s_err_i || t, s_rty_i}) : 32'd0);
    endtask

    task automatic adv();
        bit t, stb;
        @(posedge wb_clk);
        t = timed_out();
        stb = (own == 1 ? m0_stb_i : own == 2 ? m1_stb_i : 1'b0) && !t;
        if (!wb_rst_n) begin
            own = 0; last = 1; cnt = 0;
        end else begin
            if (own == 0 || t || s_ack_i || s_err_i) cnt = 0;
            else if (stb) cnt++;
            if (own == 0) begin
                if (m0_cyc_i && m1_cyc_i) own = last ? 1 : 2;
                else if (m0_cyc_i) own = 1;
                else if (m1_cyc_i) own = 2;
            end else if (own == 1 && !m0_cyc_i) begin
                own = 0; last = 0;
            end else if (own == 2 && !m1_cyc_i) begin
                own = 0; last = 1;
            end
        end
        @(negedge wb_clk);
    endtask

    task automatic quiet();
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
    endtask

    task automatic reset_dut();
        quiet();
        wb_rst_n = 0;
        adv(); adv();
        wb_rst_n = 1;
    endtask

    initial begin
        @(negedge wb_clk);
        reset_dut();
        settle();
        chk("rst_grant", 32'(grant_o), 32'd0);
        // single m0 write
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 3'd0; m0_dat_i = 8'hA5;
        settle(); chk("t1_pre", 32'(grant_o), 32'd0); adv();
        s_ack_i = 1;
        settle();
        chk("t1_grant", 32'(grant_o), 32'd1);
        chk("t1_sdat", 32'(s_dat_o), 32'hA5);
        chk("t1_ack", 32'(m0_ack_o), 32'd1);
        chk("t1_m1", 32'({m1_dat_o, m1_ack_o, m1_err_o, m1_rty_o}), 32'd0);
        adv();
        quiet(); settle(); adv(); settle(); chk("t1_idle", 32'(grant_o), 32'd0);
        // simultaneous request after reset: m0 first, one idle cycle, then m1
        reset_dut();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0;
        settle(); adv(); settle(); chk("t2_g0", 32'(grant_o), 32'd1);
        m0_cyc_i = 0; m0_stb_i = 0;
        adv(); settle(); chk("t2_gap", 32'(grant_o), 32'd0);
        adv(); settle(); chk("t2_g1", 32'(grant_o), 32'd2);
        // m1 burst of three accesses while m0 waits
        m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1;
        m1_we_i = 1; m1_adr_i = 3'd1; m1_dat_i = 8'hFF;
        settle(); chk("t4_w", 32'({grant_o, m0_ack_o}), 32'b100); adv();
        m1_we_i = 0; m1_adr_i = 3'd0; s_dat_i = 8'h3C;
        settle(); chk("t4_r0", 32'(m1_dat_o), 32'h3C); adv();
        m1_adr_i = 3'd1; s_dat_i = 8'hFF;
        settle(); chk("t4_r1", 32'(m1_dat_o), 32'hFF); adv();
        // reset while m1 owns with stb pending and slave acking
        wb_rst_n = 0;
        settle(); adv(); settle();
        chk("t5_rst", 32'({grant_o, s_cyc_o, m1_ack_o}), 32'd0);
        wb_rst_n = 1;
        adv(); settle(); chk("t5_tie", 32'(grant_o), 32'd1);
        quiet(); adv(); settle(); adv();
`ifdef GPIO_ARB_TIMEOUT_EN
        m0_cyc_i = 1; m0_stb_i = 1;
        settle(); adv();
        for (int i = 0; i < 5; i++) begin
            settle(); chk("t6_err", 32'(m0_err_o), 32'(i == 4)); adv();
        end
        for (int i = 0; i < 6; i++) begin settle(); adv(); end
        quiet(); settle(); adv();
`endif
        // continuous single-access alternation
        for (int i = 0; i < 12; i++) begin
            m0_cyc_i = own != 1 || m0_cyc_i == 0 ? 1'b1 : 1'b0;
            m1_cyc_i = own != 2 || m1_cyc_i == 0 ? 1'b1 : 1'b0;
            m0_stb_i = m0_cyc_i; m1_stb_i = m1_cyc_i; s_ack_i = 1;
            settle(); adv();
        end
        quiet(); settle(); adv();
        for (int i = 0; i < 3000; i++) begin
            m0_cyc_i = m0_cyc_i ? $urandom_range(0, 3) != 0 : 1'($urandom_range(0, 1));
            m1_cyc_i = m1_cyc_i ? $urandom_range(0, 3) != 0 : 1'($urandom_range(0, 1));
            m0_stb_i = m0_cyc_i && 1'($urandom_range(0, 1));
            m1_stb_i = m1_cyc_i && 1'($urandom_range(0, 1));
            m0_adr_i = 3'($urandom); m0_dat_i = 8'($urandom); m0_we_i = 1'($urandom);
            m1_adr_i = 3'($urandom); m1_dat_i = 8'($urandom); m1_we_i = 1'($urandom);
            s_dat_i = 8'($urandom);
            s_ack_i = $urandom_range(0, 2) == 0;
            s_err_i = $urandom_range(0, 7) == 0;
            s_rty_i = $urandom_range(0, 7) == 0;
            wb_rst_n = $urandom_range(0, 199) != 0;
            settle(); adv();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
